// File: rtl/csr_periph_pkg.sv
// Purpose:      shared CSR addresses, modify-operation encodings and the read-modify helper.
// Latency:      n/a (declarations only).
// Backpressure: n/a.
// Contents: counter/ID CSR address constants, MOD_* encodings of the 3-bit modify
// field, csr_is_write() and csr_apply().
package csr_periph_pkg;

  // Counter CSRs, machine-mode read/write views
  localparam logic [11:0] MCYCLE    = 12'hB00;
  localparam logic [11:0] MINSTRET  = 12'hB02;
  localparam logic [11:0] MCYCLEH   = 12'hB80;
  localparam logic [11:0] MINSTRETH = 12'hB82;

  // Read-only aliases; time shares the cycle counter
  localparam logic [11:0] CYCLE     = 12'hC00;
  localparam logic [11:0] TIME      = 12'hC01;
  localparam logic [11:0] INSTRET   = 12'hC02;
  localparam logic [11:0] CYCLEH    = 12'hC80;
  localparam logic [11:0] TIMEH     = 12'hC81;
  localparam logic [11:0] INSTRETH  = 12'hC82;

  // Identification registers, all hard-wired to zero
  localparam logic [11:0] MVENDORID = 12'hF11;
  localparam logic [11:0] MARCHID   = 12'hF12;
  localparam logic [11:0] MIMPID    = 12'hF13;
  localparam logic [11:0] MHARTID   = 12'hF14;

  // Encodings of the modify field; 4..7 behave as MOD_NONE
  localparam logic [2:0] MOD_NONE  = 3'd0;
  localparam logic [2:0] MOD_WRITE = 3'd1;
  localparam logic [2:0] MOD_SET   = 3'd2;
  localparam logic [2:0] MOD_CLEAR = 3'd3;

  // True for the encodings that change a register
  function automatic logic csr_is_write(input logic [2:0] op);
    return (op == MOD_WRITE) || (op == MOD_SET) || (op == MOD_CLEAR);
  endfunction

  // New register value for a given modify operation
  function automatic logic [31:0] csr_apply(input logic [2:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      MOD_WRITE: res = wdata;
      MOD_SET:   res = old | wdata;
      MOD_CLEAR: res = old & ~wdata;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_pin_reg.sv
// Purpose:      read/write output-pin CSR with its own address decode.
// Latency:      read data 1 cycle after the request; pins update the cycle after a modify.
// Backpressure: none, accepts a read and a modify every cycle.
// Ports: clk_i/rstn_i clock and async active-low reset; read_i/addr_i read request;
//        modify_i/wdata_i/q_addr_i modify of the previous cycle's address;
//        rdata_o/valid_o registered read response (zero when not hit); pins_o register.
module csr_pin_reg
  import csr_periph_pkg::*;
#(
  parameter logic [11:0]      BASE_ADDR   = 12'hBC1,
  parameter int               COUNT       = 1,
  parameter logic [COUNT-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             read_i,
  input  logic [11:0]      addr_i,
  input  logic [2:0]       modify_i,
  input  logic [COUNT-1:0] wdata_i,
  input  logic [11:0]      q_addr_i,
  output logic [31:0]      rdata_o,
  output logic             valid_o,
  output logic [COUNT-1:0] pins_o
);

  logic [COUNT-1:0] pins_q, pins_d;
  logic             valid_q, valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_val;

  always_comb begin
    pins_d = pins_q;
    if (q_addr_i == BASE_ADDR) begin
      case (modify_i)
        MOD_WRITE: pins_d = wdata_i;
        MOD_SET:   pins_d = pins_q | wdata_i;
        MOD_CLEAR: pins_d = pins_q & ~wdata_i;
        default:   pins_d = pins_q;
      endcase
    end
  end

  // Zero-extend without a replication that would be empty at COUNT == 32
  always_comb begin
    rd_val             = '0;
    rd_val[COUNT-1:0]  = pins_q;
  end

  // Read samples the pre-modify value, so a same-cycle modify is not visible
  always_comb begin
    valid_d = read_i && (addr_i == BASE_ADDR);
    rdata_d = valid_d ? rd_val : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pins_q  <= RESET_VALUE;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      pins_q  <= pins_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  assign pins_o  = pins_q;
  assign valid_o = valid_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/csr_sys_periph.sv
// Purpose:      machine-level CSR slave: cycle/time/instret counters, ID/kHz registers, pin register.
// Latency:      read data/valid 1 cycle after the request; modify lands at the end of its cycle.
// Backpressure: none, always ready; rdata/valid are zero when not addressed so they can be ORed.
// Ports: clk/rstn clock and async active-low reset; retired instruction-retire pulse;
//        read/addr read request; modify/wdata operation on the previous cycle's addr;
//        rdata/valid registered response; pins pin-register contents.
// Build option CSR_COUNTER_HIGH_EN: 64-bit counters with the high halves mapped;
// without it the counters are 32 bits and the high-half addresses are unmapped.
module csr_sys_periph
  import csr_periph_pkg::*;
#(
  parameter logic [11:0]           ID_BASE_ADDR     = 12'hFC0,
  parameter int unsigned           KHZ              = 1000,
  parameter logic [11:0]           PINS_BASE_ADDR   = 12'hBC1,
  parameter int                    PINS_COUNT       = 1,
  parameter logic [PINS_COUNT-1:0] PINS_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  retired,
  input  logic                  read,
  input  logic [2:0]            modify,
  input  logic [31:0]           wdata,
  input  logic [11:0]           addr,
  output logic [31:0]           rdata,
  output logic                  valid,
  output logic [PINS_COUNT-1:0] pins
);

  // Address of the previous cycle; the target of this cycle's modify
  logic [11:0] addr_q;

  logic [31:0] cyc_lo_q, cyc_lo_d;
  logic [31:0] ins_lo_q, ins_lo_d;
`ifdef CSR_COUNTER_HIGH_EN
  logic [31:0] cyc_hi_q, cyc_hi_d;
  logic [31:0] ins_hi_q, ins_hi_d;
`endif

  logic        wr_en;
  logic        rd_hit;
  logic [31:0] rd_val;
  logic        ctr_valid_q, ctr_valid_d;
  logic [31:0] ctr_rdata_q, ctr_rdata_d;
  logic        pin_valid;
  logic [31:0] pin_rdata;

  assign wr_en = csr_is_write(modify);

  // Counter next state: a modify of either half replaces that cycle's increment,
  // and the other half is held so no carry leaks across the write.
  always_comb begin
    cyc_lo_d = cyc_lo_q + 32'd1;
    ins_lo_d = ins_lo_q + {31'd0, retired};
`ifdef CSR_COUNTER_HIGH_EN
    cyc_hi_d = cyc_hi_q + {31'd0, &cyc_lo_q};
    ins_hi_d = ins_hi_q + {31'd0, retired & (&ins_lo_q)};
`endif
    if (wr_en) begin
      case (addr_q)
        MCYCLE: begin
          cyc_lo_d = csr_apply(modify, cyc_lo_q, wdata);
`ifdef CSR_COUNTER_HIGH_EN
          cyc_hi_d = cyc_hi_q;
`endif
        end
        MINSTRET: begin
          ins_lo_d = csr_apply(modify, ins_lo_q, wdata);
`ifdef CSR_COUNTER_HIGH_EN
          ins_hi_d = ins_hi_q;
`endif
        end
`ifdef CSR_COUNTER_HIGH_EN
        MCYCLEH: begin
          cyc_hi_d = csr_apply(modify, cyc_hi_q, wdata);
          cyc_lo_d = cyc_lo_q;
        end
        MINSTRETH: begin
          ins_hi_d = csr_apply(modify, ins_hi_q, wdata);
          ins_lo_d = ins_lo_q;
        end
`endif
        default: ;
      endcase
    end
  end

  // Read decode for counters and IDs; the pin register decodes itself
  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (addr)
      MCYCLE, CYCLE, TIME:                   rd_val = cyc_lo_q;
      MINSTRET, INSTRET:                     rd_val = ins_lo_q;
`ifdef CSR_COUNTER_HIGH_EN
      MCYCLEH, CYCLEH, TIMEH:                rd_val = cyc_hi_q;
      MINSTRETH, INSTRETH:                   rd_val = ins_hi_q;
`endif
      MVENDORID, MARCHID, MIMPID, MHARTID:   rd_val = '0;
      default:                               rd_hit = 1'b0;
    endcase
    if (addr == ID_BASE_ADDR) begin
      rd_hit = 1'b1;
      rd_val = KHZ;
    end
  end

  always_comb begin
    ctr_valid_d = read && rd_hit;
    ctr_rdata_d = ctr_valid_d ? rd_val : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      cyc_lo_q    <= '0;
      ins_lo_q    <= '0;
`ifdef CSR_COUNTER_HIGH_EN
      cyc_hi_q    <= '0;
      ins_hi_q    <= '0;
`endif
      ctr_valid_q <= 1'b0;
      ctr_rdata_q <= '0;
    end else begin
      addr_q      <= addr;
      cyc_lo_q    <= cyc_lo_d;
      ins_lo_q    <= ins_lo_d;
`ifdef CSR_COUNTER_HIGH_EN
      cyc_hi_q    <= cyc_hi_d;
      ins_hi_q    <= ins_hi_d;
`endif
      ctr_valid_q <= ctr_valid_d;
      ctr_rdata_q <= ctr_rdata_d;
    end
  end

  csr_pin_reg #(
    .BASE_ADDR   (PINS_BASE_ADDR),
    .COUNT       (PINS_COUNT),
    .RESET_VALUE (PINS_RESET_VALUE)
  ) u_pin_reg (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .read_i   (read),
    .addr_i   (addr),
    .modify_i (modify),
    .wdata_i  (wdata[PINS_COUNT-1:0]),
    .q_addr_i (addr_q),
    .rdata_o  (pin_rdata),
    .valid_o  (pin_valid),
    .pins_o   (pins)
  );

  // Both response sources are zero when idle, so OR-combining is safe
  assign rdata = ctr_rdata_q | pin_rdata;
  assign valid = ctr_valid_q | pin_valid;

endmodule

// File: tb/tb_csr_sys_periph.sv
// Purpose:      directed self-checking bench for csr_sys_periph with a scoreboard of read responses.
// Latency:      expects read responses one cycle after the request.
// Backpressure: n/a.
// Honours CSR_COUNTER_HIGH_EN the same way as the design.
module tb_csr_sys_periph;

`ifdef CSR_COUNTER_HIGH_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif
  localparam logic [63:0] CMASK = HI_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn;
  logic        retired;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic [0:0]  pins;

  csr_sys_periph dut (
    .clk     (clk),
    .rstn    (rstn),
    .retired (retired),
    .read    (read),
    .modify  (modify),
    .wdata   (wdata),
    .addr    (addr),
    .rdata   (rdata),
    .valid   (valid),
    .pins    (pins)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference state: counter values visible during the current cycle
  logic [63:0] m_cyc, m_ins;
  logic        m_pin;
  logic [11:0] m_qaddr;

  function automatic logic [31:0] m_apply(input logic [2:0] op, input logic [31:0] o,
                                          input logic [31:0] w);
    case (op)
      3'd1:    return w;
      3'd2:    return o | w;
      3'd3:    return o & ~w;
      default: return o;
    endcase
  endfunction

  function automatic exp_t model_read(input logic [11:0] a, input string tag);
    exp_t e;
    e.v = 1'b1;
    e.d = 32'd0;
    e.tag = tag;
    case (a)
      12'hB00, 12'hC00, 12'hC01: e.d = m_cyc[31:0];
      12'hB02, 12'hC02:          e.d = m_ins[31:0];
      12'hB80, 12'hC80, 12'hC81: if (HI_EN) e.d = m_cyc[63:32]; else e.v = 1'b0;
      12'hB82, 12'hC82:          if (HI_EN) e.d = m_ins[63:32]; else e.v = 1'b0;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: e.d = 32'd0;
      12'hFC0:                   e.d = 32'd1000;
      12'hBC1:                   e.d = {31'd0, m_pin};
      default:                   e.v = 1'b0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at posedge+1, update the model at the edge, check at next posedge+1
  task automatic step(input logic rd, input logic [11:0] a, input logic [2:0] mod,
                      input logic [31:0] wd, input logic ret, input string tag);
    logic        wr;
    logic [31:0] t;
    exp_t        e;
    read = rd; addr = a; modify = mod; wdata = wd; retired = ret;
    if (rd) sb.push_back(model_read(a, tag));
    @(posedge clk);
    wr = (mod == 3'd1) || (mod == 3'd2) || (mod == 3'd3);
    if (wr && m_qaddr == 12'hB00)
      m_cyc = {m_cyc[63:32], m_apply(mod, m_cyc[31:0], wd)};
    else if (wr && HI_EN && m_qaddr == 12'hB80)
      m_cyc = {m_apply(mod, m_cyc[63:32], wd), m_cyc[31:0]};
    else
      m_cyc = (m_cyc + 64'd1) & CMASK;
    if (wr && m_qaddr == 12'hB02)
      m_ins = {m_ins[63:32], m_apply(mod, m_ins[31:0], wd)};
    else if (wr && HI_EN && m_qaddr == 12'hB82)
      m_ins = {m_apply(mod, m_ins[63:32], wd), m_ins[31:0]};
    else
      m_ins = (m_ins + {63'd0, ret}) & CMASK;
    if (wr && m_qaddr == 12'hBC1) begin
      t = m_apply(mod, {31'd0, m_pin}, wd);
      m_pin = t[0];
    end
    m_qaddr = a;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, " valid"}, {31'd0, valid}, {31'd0, e.v});
      check({e.tag, " rdata"}, rdata, e.d);
    end else begin
      check({tag, " idle valid"}, {31'd0, valid}, 32'd0);
      check({tag, " idle rdata"}, rdata, 32'd0);
    end
    check({tag, " pins"}, {31'd0, pins}, {31'd0, m_pin});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; read = 1'b0; modify = 3'd0; wdata = 32'd0; addr = 12'd0; retired = 1'b0;
    m_cyc = '0; m_ins = '0; m_pin = 1'b0; m_qaddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset pins", {31'd0, pins}, 32'd0);
    rstn = 1'b1;

    // Consecutive cycle reads count up by one
    for (int i = 0; i < 5; i++) step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cycle_seq");
    step(1'b1, 12'hC01, 3'd0, 32'd0, 1'b0, "time_alias");

    // Low-half wrap carries into the high half
    step(1'b0, 12'hB00, 3'd0, 32'd0, 1'b0, "wr_setup");
    step(1'b0, 12'h000, 3'd1, 32'hFFFF_FFFF, 1'b0, "wr_mcycle");
    step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cycle_max");
    step(1'b1, 12'hC80, 3'd0, 32'd0, 1'b0, "cycleh_carry");
    step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cycle_wrapped");
    step(1'b0, 12'hB80, 3'd0, 32'd0, 1'b0, "wrh_setup");
    step(1'b0, 12'h000, 3'd1, 32'h0000_1234, 1'b0, "wr_mcycleh");
    step(1'b1, 12'hB80, 3'd0, 32'd0, 1'b0, "mcycleh_rd");
    step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cycle_lo_kept");

    // Retired pulses: 7 over 20 cycles
    step(1'b1, 12'hC02, 3'd0, 32'd0, 1'b0, "instret_pre");
    for (int i = 0; i < 20; i++) step(1'b0, 12'h000, 3'd0, 32'd0, (i % 3) == 0, "retire");
    step(1'b1, 12'hC02, 3'd0, 32'd0, 1'b0, "instret_post");

    // Instret write drops that cycle's retire, then wraps into the high half
    step(1'b0, 12'hB02, 3'd0, 32'd0, 1'b0, "wri_setup");
    step(1'b0, 12'h000, 3'd1, 32'h0000_0100, 1'b1, "wr_minstret");
    step(1'b1, 12'hB02, 3'd0, 32'd0, 1'b0, "minstret_rd");
    step(1'b0, 12'hB02, 3'd0, 32'd0, 1'b0, "wri2_setup");
    step(1'b0, 12'h000, 3'd1, 32'hFFFF_FFFF, 1'b0, "wr_minstret_max");
    step(1'b0, 12'h000, 3'd0, 32'd0, 1'b1, "retire_wrap");
    step(1'b1, 12'hC02, 3'd0, 32'd0, 1'b0, "instret_wrapped");
    step(1'b1, 12'hC82, 3'd0, 32'd0, 1'b0, "instreth_carry");

    // ID registers and unmapped address
    step(1'b1, 12'hFC0, 3'd0, 32'd0, 1'b0, "khz");
    step(1'b1, 12'hF14, 3'd0, 32'd0, 1'b0, "mhartid");
    step(1'b1, 12'hF11, 3'd0, 32'd0, 1'b0, "mvendorid");
    step(1'b1, 12'h7C0, 3'd0, 32'd0, 1'b0, "unmapped");

    // Pin register: write, clear, set; same-cycle reads see the old value
    step(1'b0, 12'hBC1, 3'd0, 32'd0, 1'b0, "pin_setup");
    step(1'b0, 12'hBC1, 3'd1, 32'd1, 1'b0, "pin_write");
    step(1'b1, 12'hBC1, 3'd3, 32'd1, 1'b0, "pin_clear");
    step(1'b1, 12'hBC1, 3'd2, 32'd1, 1'b0, "pin_set");
    step(1'b1, 12'hBC1, 3'd0, 32'd0, 1'b0, "pin_rd");
    step(1'b1, 12'hBC1, 3'd5, 32'd0, 1'b0, "pin_mod5_none");

    // Writes to read-only addresses are ignored
    step(1'b0, 12'hC00, 3'd0, 32'd0, 1'b0, "ro_setup");
    step(1'b0, 12'h000, 3'd1, 32'd0, 1'b0, "ro_write_cycle");
    step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cycle_after_ro");
    step(1'b0, 12'hF14, 3'd0, 32'd0, 1'b0, "ro2_setup");
    step(1'b1, 12'hF14, 3'd1, 32'd5, 1'b0, "ro_write_id");
    step(1'b1, 12'hF14, 3'd0, 32'd0, 1'b0, "id_after_ro");

    // Asynchronous reset mid-count
    step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "pre_reset");
    read = 1'b0; modify = 3'd0; retired = 1'b0; addr = 12'd0;
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst valid", {31'd0, valid}, 32'd0);
    check("async_rst rdata", rdata, 32'd0);
    check("async_rst pins", {31'd0, pins}, 32'd0);
    m_cyc = '0; m_ins = '0; m_pin = 1'b0; m_qaddr = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cycle_after_rst");
    step(1'b1, 12'hC02, 3'd0, 32'd0, 1'b0, "instret_after_rst");
    step(1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cycle_after_rst2");
    step(1'b0, 12'h000, 3'd0, 32'd0, 1'b0, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
